xc_rf_wb_seq: RTL
=================

# xc_rf_wb_seq

Writeback sequencer between the execute-stage result producers and the 3-read-1-write forwarding register file. It accepts one result per handshake, either a single 32-bit write or a 64-bit register-pair write, and serialises it onto the register file's single `rd_*` write port. While the high half of a pair write is still pending, it exposes that write on a forwarding port so readers never see a stale value.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  result offered
- `in_ready`  out  1  result accepted this cycle when `in_valid && in_ready`
- `in_pair`  in  1  1 = pair write (lo to even reg, hi to odd reg); 0 = single write
- `in_rd`  in  5  destination register
- `in_wdata_lo`  in  32  single-write data / pair low half
- `in_wdata_hi`  in  32  pair high half; ignored when `in_pair`=0
- `rd_wen`  out  1  register-file write enable, registered
- `rd_addr`  out  5  register-file write address, registered
- `rd_wdata`  out  32  register-file write data, registered
- `fwd_wen`  out  1  pending high-half write valid, registered
- `fwd_addr`  out  5  pending high-half address
- `fwd_wdata`  out  32  pending high-half data

## Operation
- States: IDLE (nothing pending), HI (high half of a pair awaiting its write slot).
- `in_ready` = `resetn && state==IDLE`.
- IDLE, accept with `in_pair`=0:
  - next cycle `rd_wen`=1, `rd_addr`=`in_rd`, `rd_wdata`=`in_wdata_lo`.
  - stay IDLE.
- IDLE, accept with `in_pair`=1:
  - next cycle `rd_addr`={`in_rd[4:1]`,0}, `rd_wdata`=`in_wdata_lo`.
  - the high half is captured as {`in_rd[4:1]`,1} with `in_wdata_hi`, and the state moves to HI.
  - `in_rd[0]` is ignored for pairs.
- HI:
  - `rd_*` carries the captured high write.
  - `fwd_*` is deasserted.
  - `in_ready`=0.
  - the state returns to IDLE the following edge.
- The `fwd_*` outputs present the captured high write in the same cycle that `rd_*` carries the low write of the pair. The high half is therefore visible to readers one cycle before it is committed.
- Writes to x0 are suppressed: `rd_wen`=0 whenever the target address is 0. A pair to x0/x1 suppresses only the low half. `fwd_wen` obeys the same rule (it is never asserted for address 0, which cannot arise for an odd address).
- No input is accepted and nothing new is captured when the handshake is not met. `rd_wen`=0 in any cycle that follows no acceptance and no HI state.
- `rd_addr`, `rd_wdata`, `fwd_addr` and `fwd_wdata` hold their last value when the corresponding enable is 0.

## Timing
- Latency: acceptance edge to `rd_wen`=1 is 1 cycle. A pair's high write lands 2 cycles after acceptance.
- Throughput:
  - singles: 1 per cycle, back-to-back.
  - pairs: 1 per 2 cycles (`in_ready` low for exactly one cycle after each pair acceptance).
- Reset: while `resetn`=0 at an edge:
  - state becomes IDLE.
  - `rd_wen`=0, `fwd_wen`=0.
  - `rd_addr`=0, `rd_wdata`=0, `fwd_addr`=0, `fwd_wdata`=0.
  - `in_ready`=0 combinationally during reset.
- Reset mid-pair: the pending high half is discarded and never written.
- A single offered in the cycle after a pair acceptance is held off by `in_ready`=0. The producer keeps `in_valid` and its data stable until acceptance.
- Outputs are purely registered; there is no combinational path from the inputs to `rd_*` or `fwd_*`. `in_ready` depends only on state and `resetn`.

## Configuration
- `XC_RF_WB_PAIR_EN` defined: pair writes are supported as described.
- Undefined:
  - `in_pair` and `in_wdata_hi` are ignored; every accepted result is a single write.
  - the HI state is not built.
  - `fwd_wen` is tied 0, and `fwd_addr`/`fwd_wdata` are tied 0.
  - `in_ready` = `resetn`.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, all outputs 0, no `rd_wen` after release until a new acceptance.
- Back-to-back singles: x5←0x11111111, x6←0x22222222 on consecutive cycles -> `rd_wen` on two consecutive cycles with those addr/data; `in_ready` constantly 1.
- Pair: `in_rd`=7, lo=0xAAAA0000, hi=0xBBBB0001 -> cycle+1: `rd`=x6/0xAAAA0000 with `fwd`=x7/0xBBBB0001; cycle+2: `rd`=x7/0xBBBB0001, `fwd_wen`=0; `in_ready`=0 for exactly one cycle.
- x0 suppression: single to x0 -> `rd_wen` stays 0. Pair to `in_rd`=0 -> only x1←hi written, at cycle+2.
- Reset mid-pair: assert `resetn`=0 in the HI cycle -> no x7 write occurs, state IDLE afterwards.
- Macro undefined: pair request `in_rd`=9 -> a single write x9←lo, `fwd_wen` never asserted, `in_ready` stays 1.

Source files
------------

// File: rtl/xc_rf_wb_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : xc_rf_wb_seq_if
// Description : Bundle between the execute-stage result producers, the
//               writeback sequencer and the register file write/forward
//               ports.
//               Producer side: in_valid/in_ready handshake plus
//                              in_pair, in_rd, in_wdata_lo, in_wdata_hi.
//               Register file side: rd_wen, rd_addr, rd_wdata (commit port)
//                              and fwd_wen, fwd_addr, fwd_wdata (pending
//                              high-half forward port).
//               master : the result producer / observer side
//               slave  : the sequencer (xc_rf_wb_seq)
// Revision    : 1.0 - initial release
// ============================================================================
interface xc_rf_wb_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_pair;
    logic [4:0]  in_rd;
    logic [31:0] in_wdata_lo;
    logic [31:0] in_wdata_hi;

    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;

    logic        fwd_wen;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_wdata;

    modport master (
        output in_valid, in_pair, in_rd, in_wdata_lo, in_wdata_hi,
        input  in_ready,
        input  rd_wen, rd_addr, rd_wdata,
        input  fwd_wen, fwd_addr, fwd_wdata
    );

    modport slave (
        input  in_valid, in_pair, in_rd, in_wdata_lo, in_wdata_hi,
        output in_ready,
        output rd_wen, rd_addr, rd_wdata,
        output fwd_wen, fwd_addr, fwd_wdata
    );
endinterface
`default_nettype wire

// File: rtl/xc_rf_wb_seq.sv
`default_nettype none
// ============================================================================
// Module      : xc_rf_wb_seq
// Description : Writeback sequencer. Accepts one execute result per
//               handshake (single 32-bit write or 64-bit register-pair
//               write) and serialises it onto the register file's single
//               write port. While the high half of a pair is waiting for
//               its write slot it is presented on the forwarding port.
// Ports       : clock  - sole clock, rising edge
//               resetn - synchronous, active-low reset
//               bus    - xc_rf_wb_seq_if.slave (producer handshake,
//                        rd_* commit port, fwd_* forward port)
// Config      : XC_RF_WB_PAIR_EN - when defined, pair writes and the
//               forward port are built; otherwise every accepted result is
//               a single write, fwd_* is tied to 0 and in_ready = resetn.
// Revision    : 1.0 - initial release
// ============================================================================
module xc_rf_wb_seq (
    input  wire logic         clock,
    input  wire logic         resetn,
    xc_rf_wb_seq_if.slave     bus
);

    // ------------------------------------------------------------------
    // Commit port registers
    // ------------------------------------------------------------------
    logic        r_rd_wen;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd_wdata;

    logic        w_rd_wen_nxt;
    logic [4:0]  w_rd_addr_nxt;
    logic [31:0] w_rd_wdata_nxt;

    logic        w_ready;
    logic        w_accept;

`ifdef XC_RF_WB_PAIR_EN
    // ------------------------------------------------------------------
    // Pair support: state machine and forward port registers. The forward
    // registers double as the capture store for the pending high half;
    // they keep their value in the HI cycle, where the commit port reads
    // them back.
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_fwd_wen;
    logic [4:0]  r_fwd_addr;
    logic [31:0] r_fwd_wdata;

    logic        w_fwd_wen_nxt;
    logic [4:0]  w_fwd_addr_nxt;
    logic [31:0] w_fwd_wdata_nxt;

    // Pair halves always target an even/odd register couple; in_rd[0]
    // plays no part.
    logic [4:0]  w_pair_lo_addr;
    logic [4:0]  w_pair_hi_addr;

    assign w_pair_lo_addr = {bus.in_rd[4:1], 1'b0};
    assign w_pair_hi_addr = {bus.in_rd[4:1], 1'b1};

    assign w_ready = resetn && (r_state == ST_IDLE);
`else
    // Pair inputs have no function in this build.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{bus.in_pair, bus.in_wdata_hi};

    assign w_ready = resetn;
`endif

    assign w_accept = bus.in_valid && w_ready;

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Address and data registers only
    // load when the corresponding enable is set, so a suppressed x0 write
    // leaves them holding the previous write.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_wen_nxt    = 1'b0;
        w_rd_addr_nxt   = r_rd_addr;
        w_rd_wdata_nxt  = r_rd_wdata;
`ifdef XC_RF_WB_PAIR_EN
        w_state_nxt     = r_state;
        w_fwd_wen_nxt   = 1'b0;
        w_fwd_addr_nxt  = r_fwd_addr;
        w_fwd_wdata_nxt = r_fwd_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.in_pair) begin
                        // Low half commits next cycle unless it targets x0.
                        if (w_pair_lo_addr != 5'd0) begin
                            w_rd_wen_nxt   = 1'b1;
                            w_rd_addr_nxt  = w_pair_lo_addr;
                            w_rd_wdata_nxt = bus.in_wdata_lo;
                        end
                        // High half is odd, hence never x0: always captured
                        // and forwarded while the low half commits.
                        w_fwd_wen_nxt   = 1'b1;
                        w_fwd_addr_nxt  = w_pair_hi_addr;
                        w_fwd_wdata_nxt = bus.in_wdata_hi;
                        w_state_nxt     = ST_HI;
                    end else begin
                        if (bus.in_rd != 5'd0) begin
                            w_rd_wen_nxt   = 1'b1;
                            w_rd_addr_nxt  = bus.in_rd;
                            w_rd_wdata_nxt = bus.in_wdata_lo;
                        end
                    end
                end
            end
            ST_HI: begin
                // Commit the captured high half; the forward port drops.
                if (r_fwd_addr != 5'd0) begin
                    w_rd_wen_nxt   = 1'b1;
                    w_rd_addr_nxt  = r_fwd_addr;
                    w_rd_wdata_nxt = r_fwd_wdata;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
`else
        if (w_accept && (bus.in_rd != 5'd0)) begin
            w_rd_wen_nxt   = 1'b1;
            w_rd_addr_nxt  = bus.in_rd;
            w_rd_wdata_nxt = bus.in_wdata_lo;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State / output registers. Reset discards any pending high half.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_rd_wen    <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rd_wdata  <= 32'd0;
`ifdef XC_RF_WB_PAIR_EN
            r_state     <= ST_IDLE;
            r_fwd_wen   <= 1'b0;
            r_fwd_addr  <= 5'd0;
            r_fwd_wdata <= 32'd0;
`endif
        end else begin
            r_rd_wen    <= w_rd_wen_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rd_wdata  <= w_rd_wdata_nxt;
`ifdef XC_RF_WB_PAIR_EN
            r_state     <= w_state_nxt;
            r_fwd_wen   <= w_fwd_wen_nxt;
            r_fwd_addr  <= w_fwd_addr_nxt;
            r_fwd_wdata <= w_fwd_wdata_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_ready;
    assign bus.rd_wen    = r_rd_wen;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.rd_wdata  = r_rd_wdata;

`ifdef XC_RF_WB_PAIR_EN
    assign bus.fwd_wen   = r_fwd_wen;
    assign bus.fwd_addr  = r_fwd_addr;
    assign bus.fwd_wdata = r_fwd_wdata;
`else
    assign bus.fwd_wen   = 1'b0;
    assign bus.fwd_addr  = 5'd0;
    assign bus.fwd_wdata = 32'd0;
`endif

endmodule
`default_nettype wire
